spi_transmitter: RTL and testbench

SPI_TRANSMITTER -- requirements
Module: spi_transmitter

---
 rtl/spi_transmitter_pkg.sv | 24 ++
 rtl/spi_transmitter_transmitterbuffer.sv | 61 ++++++
 rtl/spi_transmitter.sv | 141 ++++++++++++++
 tb/tb_spi_transmitter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_transmitter_pkg.sv
// Shared SPI-SD constants: transmitter FSM encoding, parameter defaults,
// bus idle levels, and the matching receiver-side defaults.
package spi_transmitter_pkg;

  // Transmitter defaults
  localparam int SPI_TX_DEPTH_DEF = 8;  // FIFO depth in bytes
  localparam int SPI_TX_DIV_DEF   = 4;  // clk cycles per SCLK half-period

  // Receiver defaults, kept beside the transmitter so both ends agree
  localparam int SPI_RX_DEPTH_DEF = 8;
  localparam int SPI_RX_DIV_DEF   = 4;

  // Mode-0 bus idle levels
  localparam logic SPI_SCLK_IDLE = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b1;

  // Shifter states
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spi_transmitter_transmitterbuffer.sv
// Byte FIFO feeding the SPI shifter. Wrap-around pointers plus an explicit
// count so full/empty can be registered. A put while full is only taken when
// a pop frees the slot in the same cycle.
module transmitterbuffer
  import spi_transmitter_pkg::*;
#(
  parameter int DEPTH = SPI_TX_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     put,
  input  logic                     pop,
  input  logic [7:0]               in,
  output logic [7:0]               data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_nxt;
  logic          accept, pop_ok;

  assign pop_ok    = pop && !empty;
  assign accept    = put && (!full || pop_ok);
  assign count_nxt = count + (AW+1)'(accept) - (AW+1)'(pop_ok);
  assign data      = mem[rptr];

  // Pointer/count/flag update; flush outranks put and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (accept && !flush) mem[wptr] <= in;
  end

endmodule

// File: rtl/spi_transmitter.sv
// SPI mode-0 transmitter: byte FIFO plus a LOW/HIGH half-period shifter.
// Bytes go out MSB first; consecutive bytes are chained with no idle gap.
module spi_transmitter
  import spi_transmitter_pkg::*;
#(
  parameter int DEPTH = SPI_TX_DEPTH_DEF,
  parameter int DIV   = SPI_TX_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset,
  input  logic       put,
  input  logic [7:0] in,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       sent,
  output logic       sclk,
  output logic       mosi
);

  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  tx_state_e          state, state_nxt;
  logic [DIVW-1:0]    div_cnt, div_nxt;
  logic [2:0]         bit_cnt, bit_nxt;
  logic [7:0]         shreg, sh_nxt;
  logic               sclk_nxt, mosi_nxt, sent_nxt;
  logic               fifo_pop;
  logic [7:0]         fifo_data;
  logic [$clog2(DEPTH):0] fifo_count;

  transmitterbuffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (reset),
    .put   (put),
    .pop   (fifo_pop),
    .in    (in),
    .data  (fifo_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // count tracks empty exactly (same edge), so this is "state!=IDLE || !empty"
  assign busy = (state != TX_IDLE) || (fifo_count != '0);

  // Shifter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= SPI_SCLK_IDLE;
      mosi    <= SPI_MOSI_IDLE;
      sent    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= sh_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      sent    <= sent_nxt;
    end
  end

  // Next-state: half-period divider, bit sequencing and FIFO pops
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    sclk_nxt  = sclk;
    mosi_nxt  = mosi;
    sent_nxt  = 1'b0;
    fifo_pop  = 1'b0;
    if (reset) begin
      // Abandon any byte in flight; FIFO flushes on the same edge
      state_nxt = TX_IDLE;
      div_nxt   = '0;
      bit_nxt   = '0;
      sclk_nxt  = SPI_SCLK_IDLE;
      mosi_nxt  = SPI_MOSI_IDLE;
    end else begin
      unique case (state)
        TX_IDLE: begin
          if (!empty) begin
            fifo_pop  = 1'b1;
            sh_nxt    = fifo_data;
            mosi_nxt  = fifo_data[7];
            bit_nxt   = 3'd7;
            div_nxt   = '0;
            state_nxt = TX_LOW;
          end
        end
        TX_LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_nxt   = '0;
            sclk_nxt  = 1'b1;
            state_nxt = TX_HIGH;
          end else begin
            div_nxt = div_cnt + DIVW'(1);
          end
        end
        TX_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_nxt  = '0;
            sclk_nxt = 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_nxt   = bit_cnt - 3'd1;
              sh_nxt    = {shreg[6:0], 1'b0};
              mosi_nxt  = shreg[6];
              state_nxt = TX_LOW;
            end else begin
              sent_nxt = 1'b1;
              if (!empty) begin
                // Chain straight into the next byte
                fifo_pop  = 1'b1;
                sh_nxt    = fifo_data;
                mosi_nxt  = fifo_data[7];
                bit_nxt   = 3'd7;
                state_nxt = TX_LOW;
              end else begin
                mosi_nxt  = SPI_MOSI_IDLE;
                state_nxt = TX_IDLE;
              end
            end
          end else begin
            div_nxt = div_cnt + DIVW'(1);
          end
        end
        default: state_nxt = TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transmitter.sv
// Bench for spi_transmitter (DIV=2, DEPTH=8). A transaction-level model
// (byte queue + cycles-remaining timer for the byte on the wire) predicts
// every output each cycle; an SCLK-edge monitor reassembles bytes.
module tb_spi_transmitter;

  localparam int DEPTH    = 8;
  localparam int DIV      = 2;
  localparam int BYTE_CYC = 16 * DIV;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       reset = 1'b0;
  logic       put   = 1'b0;
  logic [7:0] in    = 8'h00;
  logic       full, empty, busy, sent, sclk, mosi;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_transmitter #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .reset (reset),
    .put   (put),
    .in    (in),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .sent  (sent),
    .sclk  (sclk),
    .mosi  (mosi)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];       // bytes waiting in the FIFO
  logic [7:0] txlog[$];   // every byte that started transmitting
  logic [7:0] cur   = 8'h00;
  int         rem   = 0;  // clk cycles left for the byte on the wire
  bit         m_sent = 1'b0;
  bit         m_pop;
  int         epoch = 0;  // bumps on every reset/flush

  always @(posedge clk or posedge rst) begin
    if (rst || reset) begin
      q.delete();
      rem    = 0;
      m_sent = 1'b0;
      epoch++;
    end else begin
      m_sent = (rem == 1);
      m_pop  = (q.size() > 0) && (rem <= 1);
      if (m_pop) begin
        cur = q.pop_front();
        rem = BYTE_CYC;
        txlog.push_back(cur);
      end else if (rem > 0) begin
        rem--;
      end
      if (put && q.size() < DEPTH) q.push_back(in);
    end
  end

  // ---------------- per-cycle compare + byte monitor ----------------
  logic       sclk_prev = 1'b0;
  logic [7:0] rx_bits   = 8'h00;
  logic [7:0] last_rx   = 8'h00;
  int         rx_cnt = 0, rx_idx = 0, seen_epoch = 0;
  int         sclk_rises = 0, sent_cnt = 0;

  always @(negedge clk) begin
    int el, bi;
    logic e_sclk, e_mosi;
    if (rem == 0) begin
      e_sclk = 1'b0;
      e_mosi = 1'b1;
    end else begin
      el     = BYTE_CYC - rem;
      bi     = el / (2 * DIV);
      e_sclk = (el % (2 * DIV)) >= DIV;
      e_mosi = cur[7 - bi];
    end
    chk("sclk",  sclk,  e_sclk);
    chk("mosi",  mosi,  e_mosi);
    chk("sent",  sent,  m_sent);
    chk("empty", empty, q.size() == 0);
    chk("full",  full,  q.size() == DEPTH);
    chk("busy",  busy,  (rem != 0) || (q.size() != 0));

    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      rx_cnt     = 0;
      rx_idx     = txlog.size();
    end
    if (sent === 1'b1) sent_cnt++;
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      sclk_rises++;
      rx_bits = {rx_bits[6:0], mosi};
      rx_cnt++;
      if (rx_cnt == 8) begin
        rx_cnt  = 0;
        last_rx = rx_bits;
        if (rx_idx < txlog.size()) chk("rx_byte", rx_bits, txlog[rx_idx]);
        else                       chk("rx_extra", 32'd1, 32'd0);
        rx_idx++;
      end
    end
    sclk_prev = sclk;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    put = 1'b1;
    in  = b;
    tick();
    put = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && (rem != 0 || q.size() != 0); i++) tick();
    chk("drain_idle", (rem != 0 || q.size() != 0), 32'd0);
    tick();
  endtask

  initial begin
    int rx0, s0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset: no SCLK activity
    repeat (100) tick();
    chk("idle_rises", sclk_rises, 32'd0);

    // Single byte
    s0 = sent_cnt;
    put_byte(8'hA5);
    drain(200);
    chk("a5_rx", last_rx, 8'hA5);
    chk("a5_sent", sent_cnt - s0, 32'd1);
    chk("a5_busy", busy, 32'd0);

    // Two bytes back-to-back
    s0 = sent_cnt;
    put_byte(8'h3C);
    put_byte(8'hFF);
    drain(200);
    chk("b2b_sent", sent_cnt - s0, 32'd2);
    chk("b2b_rx", last_rx, 8'hFF);

    // Ten bytes: overflow drops while the shifter works on the first
    rx0 = rx_idx;
    for (int i = 0; i < 10; i++) begin
      put = 1'b1;
      in  = 8'(i);
      tick();
    end
    put = 1'b0;
    chk("ten_full", full, 32'd1);
    drain(1000);
    chk("ten_count", rx_idx - rx0, 32'd9);

    // Flush mid-byte with bytes queued, then a clean byte
    put_byte(8'h81);
    for (int i = 0; i < 3; i++) put_byte(8'(8'hC0 + i));
    repeat (18) tick();
    s0 = sent_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("flush_empty", empty, 32'd1);
    chk("flush_sclk", sclk, 32'd0);
    chk("flush_mosi", mosi, 32'd1);
    chk("flush_nosent", sent_cnt - s0, 32'd0);
    put_byte(8'h55);
    drain(200);
    chk("flush_rx55", last_rx, 8'h55);

    // Held put keeps the FIFO full; coincident put+pop is accepted
    for (int i = 0; i < 200; i++) begin
      put = 1'b1;
      in  = 8'($urandom);
      tick();
      if (i > 20) chk("hold_full", full, 32'd1);
    end
    put = 1'b0;
    drain(1000);

    // Random traffic with occasional flush and async reset
    for (int i = 0; i < 3000; i++) begin
      put   = ($urandom_range(0, 2) == 0);
      in    = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      tick();
    end
    put   = 1'b0;
    reset = 1'b0;
    drain(1000);
    chk("rx_all", rx_idx, txlog.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
